// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
//   Shared types and default widths for the two-port SDRAM request arbiter.
//   - ADDR_W_DEF / DATA_W_DEF / LEN_W_DEF : default address, line and burst-length widths
//   - arb_state_t                         : arbiter FSM states
//   - arb_req_t                           : latched request {we, addr, wdata, mask, len}
package ram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 512;
  localparam int unsigned LEN_W_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } arb_state_t;

  // Field widths follow the package defaults, which the arbiter also uses.
  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic [3:0]            mask;
    logic [LEN_W_DEF-1:0]  len;
  } arb_req_t;

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick
//   Two-way grant selection. A lone valid always wins; on a tie the port
//   that was not granted last wins.
//   Ports:
//     p0_valid, p1_valid : pending requests
//     last_grant         : 1 = port 1 was granted last, 0 = port 0
//     grant[1:0]         : one-hot grant (bit n = port n), '0 when nothing pending
module ram_arb_pick (
  input  logic       p0_valid,
  input  logic       p1_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (p0_valid && p1_valid) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (p0_valid) begin
      grant = 2'b01;
    end else if (p1_valid) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/ram_req_arbiter.sv
// ram_req_arbiter
//   Arbitrates two requesters (port 0 = fetch, port 1 = data) onto a single
//   SDRAM controller, one transaction at a time.
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     pN_valid / pN_ready      : request handshake (ready is a one-cycle accept pulse)
//     pN_we/addr/wdata/mask/len: request fields, held by the requester until ready
//     pN_rvalid / pN_rdata     : one-cycle completion pulse, read line
//     mem_ren/mem_wen          : controller enables (never both high)
//     mem_address/data_in/mask/len : latched request fields to the controller
//     mem_data_out, mem_ready  : controller read data and idle/done status
//   Build option ARB_ROUND_ROBIN_EN: ties alternate between ports; without it
//   port 1 always wins a tie.
module ram_req_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  input  logic              p1_valid,
  output logic              p0_ready,
  output logic              p1_ready,
  input  logic              p0_we,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [3:0]        p0_mask,
  input  logic [3:0]        p1_mask,
  input  logic [LEN_W-1:0]  p0_len,
  input  logic [LEN_W-1:0]  p1_len,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [3:0]        mem_mask,
  output logic [LEN_W-1:0]  mem_len,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_ready
);

  arb_state_t        state_q, state_d;
  arb_req_t          req_q, req_d;
  logic              gnt_port_q, gnt_port_d;   // 1 = port 1 owns the transaction
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic [1:0]        grant;
  logic              grant_en;
  logic              last_grant;

  ram_arb_pick u_pick (
    .p0_valid  (p0_valid),
    .p1_valid  (p1_valid),
    .last_grant(last_grant),
    .grant     (grant)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (grant_en) last_d = grant[1];
  end

  // Reset to "port 1 went last" so port 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

  assign last_grant = last_q;
`else
  // Claiming port 0 went last makes the picker hand every tie to port 1.
  assign last_grant = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    gnt_port_d = gnt_port_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    grant_en   = 1'b0;
    p0_ready   = 1'b0;
    p1_ready   = 1'b0;
    p0_rvalid  = 1'b0;
    p1_rvalid  = 1'b0;
    mem_ren    = 1'b0;
    mem_wen    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_ready && (p0_valid || p1_valid)) begin
          grant_en   = 1'b1;
          gnt_port_d = grant[1];
          if (grant[1]) begin
            req_d.we    = p1_we;
            req_d.addr  = p1_addr;
            req_d.wdata = p1_wdata;
            req_d.mask  = p1_mask;
            req_d.len   = p1_len;
          end else begin
            req_d.we    = p0_we;
            req_d.addr  = p0_addr;
            req_d.wdata = p0_wdata;
            req_d.mask  = p0_mask;
            req_d.len   = p0_len;
          end
          p0_ready = grant[0];
          p1_ready = grant[1];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        mem_ren = ~req_q.we;
        mem_wen = req_q.we;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        mem_ren = ~req_q.we;
        mem_wen = req_q.we;
        if (!mem_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Enable drops on the same cycle the controller reports done.
        if (mem_ready) begin
          state_d = RESP;
          if (!req_q.we) begin
            if (gnt_port_q) p1_rdata_d = mem_data_out;
            else            p0_rdata_d = mem_data_out;
          end
        end else begin
          mem_ren = ~req_q.we;
          mem_wen = req_q.we;
        end
      end
      RESP: begin
        p0_rvalid = ~gnt_port_q;
        p1_rvalid = gnt_port_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes stay quiet while reset is being applied.
    if (rst) begin
      p0_ready  = 1'b0;
      p1_ready  = 1'b0;
      p0_rvalid = 1'b0;
      p1_rvalid = 1'b0;
      mem_ren   = 1'b0;
      mem_wen   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      gnt_port_q <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      gnt_port_q <= gnt_port_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  assign p0_rdata    = p0_rdata_q;
  assign p1_rdata    = p1_rdata_q;
  assign mem_address = req_q.addr;
  assign mem_data_in = req_q.wdata;
  assign mem_mask    = req_q.mask;
  assign mem_len     = req_q.len;

  a_en_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(mem_ren && mem_wen));

  a_fields_stable: assert property (@(posedge clk) disable iff (rst)
    ((mem_ren || mem_wen) && $past(mem_ren || mem_wen)) |->
      $stable({mem_ren, mem_wen, mem_address, mem_data_in, mem_mask, mem_len}));

endmodule

// File: tb/tb_ram_req_arbiter.sv
// tb_ram_req_arbiter
//   Self-checking bench: a transaction-level timeline model plus an SDRAM
//   controller model with a word memory, directed scenarios and random traffic.
module tb_ram_req_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         p0_valid, p1_valid, p0_ready, p1_ready;
  logic         p0_we, p1_we;
  logic [31:0]  p0_addr, p1_addr;
  logic [511:0] p0_wdata, p1_wdata;
  logic [3:0]   p0_mask, p1_mask;
  logic [7:0]   p0_len, p1_len;
  logic         p0_rvalid, p1_rvalid;
  logic [511:0] p0_rdata, p1_rdata;
  logic         mem_ren, mem_wen;
  logic [31:0]  mem_address;
  logic [511:0] mem_data_in;
  logic [3:0]   mem_mask;
  logic [7:0]   mem_len;
  logic [511:0] mem_data_out;
  logic         mem_ready;

  ram_req_arbiter #(.ADDR_W(32), .DATA_W(512), .LEN_W(8)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p1_valid(p1_valid),
    .p0_ready(p0_ready), .p1_ready(p1_ready),
    .p0_we(p0_we), .p1_we(p1_we),
    .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_mask(p0_mask), .p1_mask(p1_mask),
    .p0_len(p0_len), .p1_len(p1_len),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_mask(mem_mask), .mem_len(mem_len),
    .mem_data_out(mem_data_out), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [511:0] wdata;
    logic [3:0]   mask;
    logic [7:0]   len;
  } req_s;

  req_s q0[$];
  req_s q1[$];

  // Model of the transaction in flight: granted at t_t, controller done at t_r.
  bit           act;
  int           t_port, t_t, t_d1, t_d2, t_r;
  req_s         t_req;
  bit           last_p1;
  logic [511:0] exp_rd [2];
  logic [511:0] seen_rd [2];
  logic [31:0]  mem [logic [31:0]];
  int           gnt_log[$];

  int  cyc;
  int  ovr_d1 = -1;
  int  ovr_d2 = -1;
  bit  rst_req, quiet, post_rst;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [511:0] line_of(input logic [31:0] a, input logic [7:0] len);
    logic [511:0] l;
    l = '0;
    for (int i = 0; i < 16; i++)
      if (i <= int'(len)) l[i*32 +: 32] = rd_word(a + 32'(i));
    return l;
  endfunction

  // Mask bit = 1 protects that byte lane in every word of the burst.
  task automatic apply_write(input req_s r);
    logic [31:0] w;
    for (int i = 0; i < 16; i++) begin
      if (i <= int'(r.len)) begin
        w = rd_word(r.addr + 32'(i));
        for (int b = 0; b < 4; b++)
          if (!r.mask[b]) w[b*8 +: 8] = r.wdata[i*32 + b*8 +: 8];
        mem[r.addr + 32'(i)] = w;
      end
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  function automatic req_s rand_req();
    req_s r;
    r.we    = 1'($urandom_range(0, 1));
    r.addr  = 32'($urandom_range(0, 40));
    r.len   = ($urandom_range(0, 3) == 0) ? 8'd15 : 8'($urandom_range(0, 15));
    r.mask  = 4'($urandom_range(0, 15));
    r.wdata = rand_line();
    return r;
  endfunction

  function automatic req_s mk_req(input logic we, input logic [31:0] a,
                                  input logic [511:0] d, input logic [3:0] m,
                                  input logic [7:0] len);
    req_s r;
    r.we = we; r.addr = a; r.wdata = d; r.mask = m; r.len = len;
    return r;
  endfunction

  // Inputs for the cycle that has just begun.
  task automatic drive();
    rst = rst_req;
    if (act && cyc >= t_t + 2 + t_d1 && cyc <= t_r - 1) mem_ready = 1'b0;
    else if (act)                                       mem_ready = 1'b1;
    else                                                mem_ready = ($urandom_range(0, 4) != 0);
    if (act && cyc == t_r && !t_req.we) mem_data_out = line_of(t_req.addr, t_req.len);
    else                                mem_data_out = rand_line();
    p0_valid = !(rst_req || quiet) && (q0.size() > 0);
    p1_valid = !(rst_req || quiet) && (q1.size() > 0);
    if (q0.size() > 0) begin
      p0_we = q0[0].we; p0_addr = q0[0].addr; p0_wdata = q0[0].wdata;
      p0_mask = q0[0].mask; p0_len = q0[0].len;
    end else begin
      p0_we = 1'b0; p0_addr = $urandom(); p0_wdata = rand_line(); p0_mask = '0; p0_len = '0;
    end
    if (q1.size() > 0) begin
      p1_we = q1[0].we; p1_addr = q1[0].addr; p1_wdata = q1[0].wdata;
      p1_mask = q1[0].mask; p1_len = q1[0].len;
    end else begin
      p1_we = 1'b0; p1_addr = $urandom(); p1_wdata = rand_line(); p1_mask = '0; p1_len = '0;
    end
  endtask

  // Check the current cycle against the timeline, advance the model, then
  // move to the next cycle and drive it.
  task automatic cycle();
    int g;
    bit en, rv;
    @(negedge clk);
    if (rst) begin
      act = 1'b0;
      last_p1 = 1'b1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
    end else begin
      if (post_rst) begin
        chk("rst_p0_ready", p0_ready, 0);     chk("rst_p1_ready", p1_ready, 0);
        chk("rst_p0_rvalid", p0_rvalid, 0);   chk("rst_p1_rvalid", p1_rvalid, 0);
        chk("rst_p0_rdata", p0_rdata, 0);     chk("rst_p1_rdata", p1_rdata, 0);
        chk("rst_mem_ren", mem_ren, 0);       chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_data_in", mem_data_in, 0);
        chk("rst_mem_mask", mem_mask, 0);     chk("rst_mem_len", mem_len, 0);
      end
      g = -1;
      if (!act && mem_ready && (p0_valid || p1_valid)) begin
        if (p0_valid && p1_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
          g = last_p1 ? 0 : 1;
`else
          g = 1;
`endif
        end else begin
          g = p0_valid ? 0 : 1;
        end
      end
      chk("p0_ready", p0_ready, g == 0);
      chk("p1_ready", p1_ready, g == 1);
      en = act && cyc >= t_t + 1 && cyc <= t_r - 1;
      chk("mem_ren", mem_ren, en && !t_req.we);
      chk("mem_wen", mem_wen, en && t_req.we);
      if (en) begin
        chk("mem_address", mem_address, t_req.addr);
        chk("mem_data_in", mem_data_in, t_req.wdata);
        chk("mem_mask", mem_mask, t_req.mask);
        chk("mem_len", mem_len, t_req.len);
      end
      rv = act && cyc == t_r + 1;
      chk("p0_rvalid", p0_rvalid, rv && t_port == 0);
      chk("p1_rvalid", p1_rvalid, rv && t_port == 1);
      if (rv) begin
        if (t_port == 0) begin chk("p0_rdata", p0_rdata, exp_rd[0]); seen_rd[0] = p0_rdata; end
        else             begin chk("p1_rdata", p1_rdata, exp_rd[1]); seen_rd[1] = p1_rdata; end
      end
      if (act && cyc == t_r) begin
        if (t_req.we) apply_write(t_req);
        else          exp_rd[t_port] = line_of(t_req.addr, t_req.len);
      end
      if (rv) act = 1'b0;
      if (g >= 0) begin
        t_port  = g;
        t_req   = (g == 1) ? q1.pop_front() : q0.pop_front();
        t_t     = cyc;
        t_d1    = (ovr_d1 >= 0) ? ovr_d1 : int'($urandom_range(0, 2));
        t_d2    = (ovr_d2 >= 0) ? ovr_d2 : int'($urandom_range(1, 3));
        t_r     = t_t + 2 + t_d1 + t_d2;
        act     = 1'b1;
        last_p1 = (g == 1);
        gnt_log.push_back(g);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic do_reset();
    rst_req = 1'b1; quiet = 1'b1;
    cycle();
    rst_req = 1'b0;
    cycle();
    post_rst = 1'b1;
    cycle();
    post_rst = 1'b0; quiet = 1'b0;
  endtask

  task automatic run_until_idle(input int maxc);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || act) && n < maxc) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL idle_timeout cyc=%0d got=busy want=idle within %0d cycles", cyc, maxc);
    end
  endtask

  initial begin : main
    logic [511:0] d, burst;
    int exp_order [8];
    int n;

    cyc = 0; rst = 1'b1; rst_req = 1'b1; quiet = 1'b1; post_rst = 1'b0;
    mem_ready = 1'b1; mem_data_out = '0;
    p0_valid = 1'b0; p1_valid = 1'b0;
    p0_we = 1'b0; p1_we = 1'b0; p0_addr = '0; p1_addr = '0;
    p0_wdata = '0; p1_wdata = '0; p0_mask = '0; p1_mask = '0; p0_len = '0; p1_len = '0;
    act = 1'b0; last_p1 = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    do_reset();

    // Single write then read on port 0.
    d = '0; d[31:0] = 32'h12345678;
    q0.push_back(mk_req(1'b1, 32'h0, d, 4'b0000, 8'd0));
    run_until_idle(100);
    seen_rd[0] = '0;
    q0.push_back(mk_req(1'b0, 32'h0, rand_line(), 4'b0000, 8'd0));
    run_until_idle(100);
    chk("model_word0", rd_word(32'h0), 32'h12345678);
    chk("single_read", seen_rd[0][31:0], 32'h12345678);

    // Masked write on port 1, read back on port 0.
    d = '0; d[31:0] = 32'hFFEEDDCC;
    q1.push_back(mk_req(1'b1, 32'h0, d, 4'b0111, 8'd0));
    run_until_idle(100);
    seen_rd[0] = '0;
    q0.push_back(mk_req(1'b0, 32'h0, rand_line(), 4'b0000, 8'd0));
    run_until_idle(100);
    chk("model_masked", rd_word(32'h0), 32'hFF345678);
    chk("masked_read", seen_rd[0][31:0], 32'hFF345678);

    // Full-line burst.
    burst = '0;
    burst[0*32 +: 32]  = 32'hDEADBEEF;
    burst[1*32 +: 32]  = 32'hFFEEDDCC;
    burst[2*32 +: 32]  = 32'h996666AA;
    burst[15*32 +: 32] = 32'h11111111;
    q1.push_back(mk_req(1'b1, 32'h100, burst, 4'b0000, 8'd15));
    run_until_idle(100);
    seen_rd[0] = '0;
    q0.push_back(mk_req(1'b0, 32'h100, rand_line(), 4'b0000, 8'd15));
    run_until_idle(100);
    chk("model_burst", line_of(32'h100, 8'd15), burst);
    chk("burst_read", seen_rd[0], burst);

    // Ties from a fresh pointer.
    do_reset();
    gnt_log.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk_req(1'b0, 32'h200 + 32'(i), rand_line(), 4'b0000, 8'd0));
      q1.push_back(mk_req(1'b0, 32'h300 + 32'(i), rand_line(), 4'b0000, 8'd0));
    end
    run_until_idle(300);
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_order = '{1, 1, 1, 1, 0, 0, 0, 0};
`endif
    chk("tie_count", gnt_log.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < gnt_log.size()) chk("tie_order", gnt_log[i], exp_order[i]);

    // Reset while the controller is still busy.
    ovr_d1 = 0; ovr_d2 = 3;
    q0.push_back(mk_req(1'b0, 32'h0, rand_line(), 4'b0000, 8'd0));
    n = 0;
    while (!(act && cyc == t_t + 2) && n < 50) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL wait_done_reach cyc=%0d got=not_reached want=reached", cyc);
    end
    do_reset();
    ovr_d1 = -1; ovr_d2 = -1;
    for (int i = 0; i < 6; i++) cycle();
    seen_rd[0] = '0;
    q0.push_back(mk_req(1'b0, 32'h0, rand_line(), 4'b0000, 8'd0));
    run_until_idle(100);
    chk("retry_read", seen_rd[0][31:0], 32'hFF345678);

    // Random traffic on both ports.
    for (int k = 0; k < 2500; k++) begin
      if (q0.size() < 3 && $urandom_range(0, 3) == 0) q0.push_back(rand_req());
      if (q1.size() < 3 && $urandom_range(0, 3) == 0) q1.push_back(rand_req());
      cycle();
    end
    run_until_idle(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
